// File: rtl/sequential_divider.sv
// sequential_divider
//   Constant-time unsigned restoring divider. One quotient bit is resolved per
//   clock; every division takes exactly WIDTH iteration cycles, including
//   divide-by-zero, which yields quotient = all ones and remainder = dividend.
//
//   Optional feature macro: DIVIDER_DIV0_FLAG_EN adds the divByZero output.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides start
//   start        division request, accepted only in IDLE
//   dividend     unsigned dividend, captured on accept
//   divisor      unsigned divisor, captured on accept
//   quotient     registered quotient, held from one DONE to the next
//   remainder    registered remainder, held from one DONE to the next
//   quotientDone one-cycle pulse while results are fresh (DONE state)
//   divByZero    (DIVIDER_DIV0_FLAG_EN only) captured divisor was zero
module sequential_divider #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             quotientDone
`ifdef DIVIDER_DIV0_FLAG_EN
   ,
   output logic             divByZero
`endif
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   // Partial remainder is stored WIDTH bits wide: after every restoring step it
   // is below the divisor (or equals the shifted-in dividend bits when the
   // divisor is zero), so its extra top bit is always zero. The WIDTH+1 bit
   // width is kept where it matters, in the shifted value and the trial.
   logic [WIDTH-1:0] r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             trial_ok;
   logic [WIDTH-1:0] q_shift;
   logic [WIDTH-1:0] r_next;

`ifdef DIVIDER_DIV0_FLAG_EN
   logic             div0_q, div0_d;
`endif

   // One restoring step, evaluated every cycle regardless of state.
   always_comb begin
      r_shift  = {r_q, q_q[WIDTH-1]};
      trial    = r_shift - {1'b0, d_q};
      trial_ok = ~trial[WIDTH];
      q_shift  = (q_q << 1) | WIDTH'(trial_ok);
      r_next   = trial_ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
   end

   always_comb begin
      state_d     = state_q;
      d_d         = d_q;
      q_d         = q_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef DIVIDER_DIV0_FLAG_EN
      div0_d      = div0_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               d_d     = divisor;
               q_d     = dividend;
               r_d     = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            q_d   = q_shift;
            r_d   = r_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               quotient_d  = q_shift;
               remainder_d = r_next;
`ifdef DIVIDER_DIV0_FLAG_EN
               div0_d      = (d_q == '0);
`endif
            end
         end
         DONE: begin
            // start is ignored here; the next request is taken in IDLE
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         d_q         <= '0;
         q_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIVIDER_DIV0_FLAG_EN
         div0_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         d_q         <= d_d;
         q_q         <= q_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef DIVIDER_DIV0_FLAG_EN
         div0_q      <= div0_d;
`endif
      end
   end

   assign quotient     = quotient_q;
   assign remainder    = remainder_q;
   assign quotientDone = (state_q == DONE);
`ifdef DIVIDER_DIV0_FLAG_EN
   assign divByZero    = div0_q;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider
//   Self-checking bench: an 8-bit instance for directed cases and a 128-bit
//   instance for randomized regression, both checked against an arithmetic
//   reference (integer / and %, with the divide-by-zero result defined as
//   quotient = all ones, remainder = dividend).
module tb_sequential_divider;

   logic         clk;
   logic         rst;

   logic         start_n;
   logic [7:0]   a_n, b_n, q_n, r_n;
   logic         done_n;

   logic         start_w;
   logic [127:0] a_w, b_w, q_w, r_w;
   logic         done_w;

`ifdef DIVIDER_DIV0_FLAG_EN
   logic         z_n, z_w;
`endif

   int n_cmp = 0;
   int n_err = 0;

   sequential_divider #(.WIDTH(8)) u_dut_n (
      .clk          (clk),
      .rst          (rst),
      .start        (start_n),
      .dividend     (a_n),
      .divisor      (b_n),
      .quotient     (q_n),
      .remainder    (r_n),
      .quotientDone (done_n)
`ifdef DIVIDER_DIV0_FLAG_EN
      ,
      .divByZero    (z_n)
`endif
   );

   sequential_divider #(.WIDTH(128)) u_dut_w (
      .clk          (clk),
      .rst          (rst),
      .start        (start_w),
      .dividend     (a_w),
      .divisor      (b_w),
      .quotient     (q_w),
      .remainder    (r_w),
      .quotientDone (done_w)
`ifdef DIVIDER_DIV0_FLAG_EN
      ,
      .divByZero    (z_w)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input logic [127:0] a, input logic [127:0] b, input int w,
                                   output logic [127:0] q, output logic [127:0] r);
      logic [127:0] mask, am, bm;
      mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
      am = a & mask;
      bm = b & mask;
      if (bm == '0) begin
         q = mask;
         r = am;
      end else begin
         q = am / bm;
         r = am % bm;
      end
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Starts one division from IDLE at a falling edge, measures edges from the
   // accept edge to the first observation of quotientDone, then checks that
   // the pulse is one cycle wide (which also returns the DUT to IDLE).
   task automatic do_op(input bit wide, input logic [127:0] a, input logic [127:0] b,
                        output int lat, output logic [127:0] q, output logic [127:0] r,
                        output logic z);
      int n;
      if (wide) begin
         start_w = 1'b1; a_w = a; b_w = b;
      end else begin
         start_n = 1'b1; a_n = a[7:0]; b_n = b[7:0];
      end
      @(negedge clk);
      start_w = 1'b0;
      start_n = 1'b0;
      lat = -1;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (wide ? done_w : done_n) begin
            lat = n;
            break;
         end
      end
      q = wide ? q_w : {120'd0, q_n};
      r = wide ? r_w : {120'd0, r_n};
`ifdef DIVIDER_DIV0_FLAG_EN
      z = wide ? z_w : z_n;
`else
      z = 1'b0;
`endif
      @(negedge clk);
      check("pulse_width", {127'd0, (wide ? done_w : done_n)}, 128'd0);
   endtask

   task automatic run_check(input bit wide, input logic [127:0] a, input logic [127:0] b,
                            input string tag);
      int lat, w;
      logic [127:0] q, r, eq, er;
      logic z;
      w = wide ? 128 : 8;
      do_op(wide, a, b, lat, q, r, z);
      ref_div(a, b, w, eq, er);
      check({tag, "_lat"}, 128'(lat), 128'(w));
      check({tag, "_q"}, q, eq);
      check({tag, "_r"}, r, er);
`ifdef DIVIDER_DIV0_FLAG_EN
      check({tag, "_div0"}, {127'd0, z}, {127'd0, (b == '0)});
`endif
   endtask

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat;
      bit saw;
      logic [127:0] a, b, eq, er;

      rst = 1'b1;
      start_n = 1'b0; a_n = '0; b_n = '0;
      start_w = 1'b0; a_w = '0; b_w = '0;
      repeat (3) @(negedge clk);
      check("rst_q8", {120'd0, q_n}, 128'd0);
      check("rst_r8", {120'd0, r_n}, 128'd0);
      check("rst_done8", {127'd0, done_n}, 128'd0);
      check("rst_q128", q_w, 128'd0);
      check("rst_done128", {127'd0, done_w}, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed 8-bit cases
      run_check(1'b0, 128'd100, 128'd7, "d100_7");
      run_check(1'b0, 128'd255, 128'd1, "d255_1");
      run_check(1'b0, 128'd5, 128'd9, "d5_9");
      run_check(1'b0, 128'd255, 128'd255, "d255_255");
      run_check(1'b0, 128'd0, 128'd3, "d0_3");
      run_check(1'b0, 128'd200, 128'd0, "d200_0");
      run_check(1'b0, 128'd9, 128'd3, "d9_3");

      // start re-asserted and operands changed during RUN: no effect
      start_n = 1'b1; a_n = 8'd100; b_n = 8'd7;
      @(negedge clk);
      a_n = 8'd50; b_n = 8'd5;
      lat = -1;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (n == 3) start_n = 1'b0;
         if (n == 4) begin
            check("hold_q_run", {120'd0, q_n}, 128'd3);
            check("hold_r_run", {120'd0, r_n}, 128'd0);
         end
         if (done_n) begin
            lat = n;
            break;
         end
      end
      check("restart_lat", 128'(lat), 128'd8);
      check("restart_q", {120'd0, q_n}, 128'd14);
      check("restart_r", {120'd0, r_n}, 128'd2);
      saw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_n) saw = 1'b1;
      end
      check("restart_no_extra", {127'd0, saw}, 128'd0);
      run_check(1'b0, 128'd50, 128'd5, "d50_5");

      // Reset mid-run aborts without a done pulse
      start_n = 1'b1; a_n = 8'd100; b_n = 8'd7;
      @(negedge clk);
      start_n = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_q", {120'd0, q_n}, 128'd0);
      check("midrst_r", {120'd0, r_n}, 128'd0);
      check("midrst_done", {127'd0, done_n}, 128'd0);
      rst = 1'b0;
      saw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_n) saw = 1'b1;
      end
      check("midrst_no_done", {127'd0, saw}, 128'd0);
      run_check(1'b0, 128'd63, 128'd8, "d63_8");

      // Randomized 128-bit regression
      for (int i = 0; i < 500; i++) begin
         a = rand128();
         case (i % 8)
            0: b = rand128();
            1: b = rand128() >> $urandom_range(0, 127);
            2: b = 128'd1;
            3: b = '1;
            4: b = 128'($urandom_range(1, 1000));
            5: begin
               b = rand128() >> $urandom_range(0, 64);
               a = a >> $urandom_range(0, 127);
            end
            6: begin
               b = rand128() >> $urandom_range(0, 127);
               a = b;
            end
            default: b = (i % 56 == 7) ? 128'd0 : (rand128() >> $urandom_range(60, 127));
         endcase
         run_check(1'b1, a, b, $sformatf("rnd%0d", i));
      end

      // Check the model's boundary corners explicitly at full width
      ref_div('1, 128'd1, 128, eq, er);
      run_check(1'b1, '1, 128'd1, "w_max_1");
      run_check(1'b1, 128'd12345, '1, "w_small_max");
      run_check(1'b1, '1, '1, "w_max_max");
      run_check(1'b1, rand128(), 128'd0, "w_div0");
      check("model_max_1", eq, '1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
